mult_requester: RTL and testbench

MULT_REQUESTER -- requirements
Module: mult_requester

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_requester_if.sv | 21 ++
 rtl/mult_req_fifo.sv | 50 +++++
 rtl/mult_requester.sv | 95 +++++++++
 tb/tb_mult_requester.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier requester slice.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } req_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/mult_requester_if.sv
// Load/done handshake between the requester and an external multi-cycle multiplier.
interface mult_requester_if #(
    parameter int WIDTH = mult_pkg::DEF_WIDTH
);
    logic               mult_ld;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_ready;
    logic               mult_done;
    logic [2*WIDTH-1:0] mult_product;

    modport master (
        output mult_ld, mult_a, mult_b,
        input  mult_ready, mult_done, mult_product
    );

    modport slave (
        input  mult_ld, mult_a, mult_b,
        output mult_ready, mult_done, mult_product
    );
endinterface

// File: rtl/mult_req_fifo.sv
// Operand-pair FIFO: registered occupancy, no write-to-read bypass, pointers wrap modulo DEPTH.
module mult_req_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage array has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mult_requester.sv
// Buffers operand pairs and feeds them one at a time to an external multiplier,
// holding each product until downstream accepts it.
module mult_requester
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    mult_requester_if.master           mbus,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_product,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       protocol_err
);
    req_state_t         state_q;
    req_state_t         state_d;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_rdata;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    assign in_ready = !fifo_full;

    mult_req_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output is defaulted before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && mbus.mult_ready) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (mbus.mult_done) state_d = HOLD;
            HOLD:    if (out_ready)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mbus.mult_ld = (state_q == ISSUE);
    assign mbus.mult_a  = a_q;
    assign mbus.mult_b  = b_q;
    assign out_valid    = (state_q == HOLD);

    // Operands move only on the IDLE pop; the product is captured only in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            out_product  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (fifo_pop) begin
                {a_q, b_q} <= fifo_rdata;
            end
            if (mbus.mult_done && state_q == WAIT) begin
                out_product <= mbus.mult_product;
            end
            if (mbus.mult_done && state_q != WAIT) begin
                protocol_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_requester.sv
// Directed bench for mult_requester with a behavioural multiplier and a product scoreboard.
module tb_mult_requester;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_product;
    logic [CW-1:0]      count;
    logic               protocol_err;

    mult_requester_if #(.WIDTH(WIDTH)) mbus ();

    mult_requester #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mbus         (mbus.master),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .count        (count),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*WIDTH-1:0] exp_q [$];

    // Multiplier model controls (written by the stimulus process only).
    int   mdl_lat    = 3;
    logic hold_ready = 1'b0;
    int   stray_cnt  = 0;

    // Behavioural multiplier: latches operands on mult_ld, pulses mult_done mdl_lat cycles later.
    initial begin
        logic             busy;
        int               cnt;
        int               stray_seen;
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        busy              = 1'b0;
        cnt               = 0;
        stray_seen        = 0;
        pa                = '0;
        pb                = '0;
        mbus.mult_ready   = 1'b1;
        mbus.mult_done    = 1'b0;
        mbus.mult_product = '0;
        forever begin
            @(negedge clk);
            mbus.mult_done = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else if (stray_cnt != stray_seen) begin
                stray_seen        = stray_seen + 1;
                mbus.mult_done    = 1'b1;
                mbus.mult_product = 16'hBEEF;
            end else if (busy) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    busy              = 1'b0;
                    mbus.mult_done    = 1'b1;
                    mbus.mult_product = (2*WIDTH)'(pa) * (2*WIDTH)'(pb);
                end
            end else if (mbus.mult_ld) begin
                busy = 1'b1;
                cnt  = mdl_lat;
                pa   = mbus.mult_a;
                pb   = mbus.mult_b;
            end
            mbus.mult_ready = !busy && !hold_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: records what the coming posedge accepts, then advances one cycle.
    task automatic cycle();
        if (in_valid && in_ready) begin
            exp_q.push_back((2*WIDTH)'(in_a) * (2*WIDTH)'(in_b));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected result", 32'(out_product), 32'hFFFF_FFFF);
            else                   check("product", 32'(out_product), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
    endtask

    task automatic push_pair(input int a, input int b);
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) cycle();
        if (!out_valid) check("out_valid timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        wait_out(50);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " count"},        32'(count),        32'd0);
        check({tag, " in_ready"},     32'(in_ready),     32'd1);
        check({tag, " mult_ld"},      32'(mbus.mult_ld), 32'd0);
        check({tag, " out_valid"},    32'(out_valid),    32'd0);
        check({tag, " out_product"},  32'(out_product),  32'd0);
        check({tag, " mult_a"},       32'(mbus.mult_a),  32'd0);
        check({tag, " mult_b"},       32'(mbus.mult_b),  32'd0);
        check({tag, " protocol_err"}, 32'(protocol_err), 32'd0);
    endtask

    initial begin
        int fa [5] = '{255, 1, 3, 200, 9};
        int fb [5] = '{255, 2, 4, 100, 9};
        int sent;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #1 check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single op: 12*13, ld two cycles after acceptance, then 10 cycles of backpressure
        push_pair(12, 13);
        check("lat c1 count", 32'(count), 32'd1);
        check("lat c1 mult_ld", 32'(mbus.mult_ld), 32'd0);
        cycle();
        check("lat c2 mult_ld", 32'(mbus.mult_ld), 32'd1);
        check("lat c2 mult_a", 32'(mbus.mult_a), 32'd12);
        check("lat c2 mult_b", 32'(mbus.mult_b), 32'd13);
        check("lat c2 count", 32'(count), 32'd0);
        push_pair(5, 7);
        wait_out(20);
        check("single product", 32'(out_product), 32'd156);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_product", 32'(out_product), 32'd156);
            check("bp mult_ld", 32'(mbus.mult_ld), 32'd0);
        end
        check("bp count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("after accept out_valid", 32'(out_valid), 32'd0);
        take_result();

        // Fill with multiplier stalled: fifth pair refused
        hold_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push_pair(fa[i], fb[i]);
        check("fill count", 32'(count), 32'd4);
        check("fill in_ready", 32'(in_ready), 32'd0);
        push_pair(fa[4], fb[4]);
        check("fill count held", 32'(count), 32'd4);
        check("fill mult_ld", 32'(mbus.mult_ld), 32'd0);
        hold_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle();
        out_ready  = 1'b0;
        check("fill drained", 32'(exp_q.size()), 32'd0);
        check("fill count end", 32'(count), 32'd0);

        // Stray done in IDLE with one pair buffered
        hold_ready = 1'b1;
        cycle();
        push_pair(6, 7);
        stray_cnt = stray_cnt + 1;
        repeat (3) cycle();
        check("stray protocol_err", 32'(protocol_err), 32'd1);
        check("stray out_valid", 32'(out_valid), 32'd0);
        check("stray count", 32'(count), 32'd1);
        hold_ready = 1'b0;
        take_result();
        check("stray sticky", 32'(protocol_err), 32'd1);

        // Reset while WAIT with two pairs queued
        mdl_lat = 10;
        push_pair(10, 10);
        push_pair(11, 11);
        push_pair(12, 12);
        check("pre-reset count", 32'(count), 32'd2);
        cycle();
        #1 reset = 1'b1;
        #1 check_reset_values("mid-wait reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        mdl_lat = 3;
        push_pair(100, 3);
        take_result();
        check("post-reset protocol_err", 32'(protocol_err), 32'd0);
        check("post-reset count", 32'(count), 32'd0);

        // Wrap: 3*DEPTH ops with random input gaps, output stalls and multiplier latency
        sent = 0;
        for (int i = 0; i < 3000 && (sent < 3 * DEPTH || exp_q.size() != 0 || out_valid); i++) begin
            mdl_lat   = $urandom_range(1, 5);
            in_valid  = (sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
            in_a      = WIDTH'($urandom_range(0, 255));
            in_b      = WIDTH'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) sent++;
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("wrap sent", 32'(sent), 32'(3 * DEPTH));
        check("wrap drained", 32'(exp_q.size()), 32'd0);
        check("wrap count", 32'(count), 32'd0);
        check("wrap protocol_err", 32'(protocol_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
